// File: rtl/distributor14_if.sv
// rtl/distributor14_if.sv - Producer/consumer bus bundle for the 1-to-4 result distributor
interface distributor14_if #(
  parameter int WIDTH = 32
);
  logic             iValid;
  logic [1:0]       iS;
  logic [WIDTH-1:0] iD;
  logic             oReady;
  logic [3:0]       iAck;
  logic [WIDTH-1:0] oZ0;
  logic [WIDTH-1:0] oZ1;
  logic [WIDTH-1:0] oZ2;
  logic [WIDTH-1:0] oZ3;
  logic [3:0]       oV;
  logic [2:0]       oCount;
  logic             oErr;

  // Producer and consumers together drive the offer and ack side
  modport master (
    output iValid, iS, iD, iAck,
    input  oReady, oZ0, oZ1, oZ2, oZ3, oV, oCount, oErr
  );

  // The distributor owns the slots and the ready/status side
  modport slave (
    input  iValid, iS, iD, iAck,
    output oReady, oZ0, oZ1, oZ2, oZ3, oV, oCount, oErr
  );
endinterface

// File: rtl/distributor14.sv
// rtl/distributor14.sv - Registered 1-to-4 result distributor with per-slot valid/ack
module distributor14 #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  distributor14_if.slave  bus
);
  logic [WIDTH-1:0] z_q [4];
  logic [WIDTH-1:0] z_d [4];
  logic [3:0]       v_q, v_d;
  logic [2:0]       count_q, count_d;
  logic             err_q, err_d;
  logic             ready;
  logic             accept;
  logic [3:0]       acked;
  logic [2:0]       n_acked;

  // Next-state: acks drain held slots, an accept (re)fills the selected slot and wins over its ack
  always_comb begin
    ready   = ~v_q[bus.iS] | bus.iAck[bus.iS];
    accept  = bus.iValid & ready;
    acked   = bus.iAck & v_q;
    n_acked = 3'd0;
    v_d     = v_q & ~acked;
    for (int k = 0; k < 4; k++) begin
      z_d[k]  = z_q[k];
      n_acked = n_acked + {2'b00, acked[k]};
      if (accept && (bus.iS == k[1:0])) begin
        z_d[k] = bus.iD;
        v_d[k] = 1'b1;
      end
    end
    count_d = count_q + {2'b00, accept} - n_acked;
    // An ack naming an empty slot is a consumer protocol violation; it is latched until reset
    err_d   = err_q | (|(bus.iAck & ~v_q));
  end

  // Slot, valid, count and error registers; reset overrides any same-cycle offer or ack
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) z_q[k] <= '0;
      v_q     <= 4'b0000;
      count_q <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) z_q[k] <= z_d[k];
      v_q     <= v_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign bus.oReady = ready;
  assign bus.oZ0    = z_q[0];
  assign bus.oZ1    = z_q[1];
  assign bus.oZ2    = z_q[2];
  assign bus.oZ3    = z_q[3];
  assign bus.oV     = v_q;
  assign bus.oCount = count_q;
  assign bus.oErr   = err_q;
endmodule

// File: tb/tb_distributor14.sv
// tb/tb_distributor14.sv - Directed and randomized self-checking bench for distributor14
module tb_distributor14;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [1:0]  s = 2'd0;
  logic [31:0] d = '0;
  logic [3:0]  ack = 4'b0000;
  int          total = 0;
  int          bad = 0;

  // Reference model: slot contents, occupancy and error flag
  logic [31:0] mz [4];
  bit          mv [4];
  bit          merr;

  distributor14_if #(.WIDTH(32)) bus ();
  assign bus.iValid = valid;
  assign bus.iS     = s;
  assign bus.iD     = d;
  assign bus.iAck   = ack;

  distributor14 #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] dut_z(input int k);
    case (k)
      0: return bus.oZ0;
      1: return bus.oZ1;
      2: return bus.oZ2;
      default: return bus.oZ3;
    endcase
  endfunction

  function automatic int occupied();
    int n = 0;
    for (int k = 0; k < 4; k++) n += mv[k] ? 1 : 0;
    return n;
  endfunction

  function automatic logic [3:0] model_v();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = mv[k];
    return v;
  endfunction

  function automatic bit model_ready();
    return !mv[s] || ack[s];
  endfunction

  // One clock edge: the model applies the slot rules to the inputs currently driven
  task automatic tick();
    bit r;
    r = model_ready();
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++) begin mz[k] = '0; mv[k] = 0; end
      merr = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (ack[k]) begin
          if (mv[k]) mv[k] = 0;
          else merr = 1;
        end
      end
      if (valid && r) begin
        mz[s] = d;
        mv[s] = 1;
      end
    end
    #1;
  endtask

  task automatic idle();
    valid = 0; ack = 4'b0000; rst = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic write_slot(input logic [1:0] sel, input logic [31:0] val);
    valid = 1; s = sel; d = val; tick(); valid = 0;
  endtask

  task automatic test_reset();
    rst = 1; valid = 1; s = 2'd2; d = 32'hDEADBEEF; ack = 4'b1111;
    tick(); tick();
    idle(); #1;
    total++; if (bus.oV !== 4'b0000) begin bad++; $display("FAIL reset_v got=%b exp=0000", bus.oV); end
    total++; if (bus.oCount !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.oCount); end
    total++; if (bus.oErr !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.oErr); end
    for (int k = 0; k < 4; k++) begin
      total++; if (dut_z(k) !== 32'h0) begin bad++; $display("FAIL reset_z%0d got=%h exp=0", k, dut_z(k)); end
    end
  endtask

  task automatic test_basic();
    valid = 1; s = 2'd1; d = 32'h12345678; #1;
    total++; if (bus.oReady !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", bus.oReady); end
    tick(); valid = 0;
    total++; if (bus.oZ1 !== 32'h12345678) begin bad++; $display("FAIL basic_z1 got=%h exp=12345678", bus.oZ1); end
    total++; if (bus.oV !== 4'b0010) begin bad++; $display("FAIL basic_v got=%b exp=0010", bus.oV); end
    total++; if (bus.oCount !== 3'd1) begin bad++; $display("FAIL basic_count got=%0d exp=1", bus.oCount); end
    ack = 4'b0010; tick(); ack = 4'b0000;
    total++; if (bus.oV !== 4'b0000) begin bad++; $display("FAIL basic_ack_v got=%b exp=0000", bus.oV); end
    total++; if (bus.oZ1 !== 32'h12345678) begin bad++; $display("FAIL basic_stale_z1 got=%h exp=12345678", bus.oZ1); end
    total++; if (bus.oErr !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", bus.oErr); end
  endtask

  task automatic test_backpressure();
    do_reset();
    write_slot(2'd3, 32'hA5A5A5A5);
    valid = 1; s = 2'd3; d = 32'h0000FFFF; ack = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (bus.oReady !== 1'b0) begin bad++; $display("FAIL bp_ready%0d got=%b exp=0", i, bus.oReady); end
      tick();
      total++; if (bus.oZ3 !== 32'hA5A5A5A5) begin bad++; $display("FAIL bp_z3_%0d got=%h exp=a5a5a5a5", i, bus.oZ3); end
      total++; if (bus.oCount !== 3'd1) begin bad++; $display("FAIL bp_count%0d got=%0d exp=1", i, bus.oCount); end
    end
    idle();
  endtask

  task automatic test_ack_refill();
    do_reset();
    write_slot(2'd0, 32'h1);
    ack = 4'b0001; valid = 1; s = 2'd0; d = 32'h2; #1;
    total++; if (bus.oReady !== 1'b1) begin bad++; $display("FAIL refill_ready got=%b exp=1", bus.oReady); end
    tick(); idle();
    total++; if (bus.oZ0 !== 32'h2) begin bad++; $display("FAIL refill_z0 got=%h exp=2", bus.oZ0); end
    total++; if (bus.oV[0] !== 1'b1) begin bad++; $display("FAIL refill_v0 got=%b exp=1", bus.oV[0]); end
    total++; if (bus.oCount !== 3'd1) begin bad++; $display("FAIL refill_count got=%0d exp=1", bus.oCount); end
  endtask

  task automatic test_fill_multi_ack();
    do_reset();
    for (int k = 0; k < 4; k++) write_slot(k[1:0], 32'(10 + k));
    total++; if (bus.oCount !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", bus.oCount); end
    for (int k = 0; k < 4; k++) begin
      total++; if (dut_z(k) !== 32'(10 + k)) begin bad++; $display("FAIL fill_z%0d got=%0d exp=%0d", k, dut_z(k), 10 + k); end
    end
    ack = 4'b1010; tick(); idle();
    total++; if (bus.oCount !== 3'd2) begin bad++; $display("FAIL multiack_count got=%0d exp=2", bus.oCount); end
    total++; if (bus.oV !== 4'b0101) begin bad++; $display("FAIL multiack_v got=%b exp=0101", bus.oV); end
  endtask

  task automatic test_error();
    do_reset();
    ack = 4'b0100; tick(); idle();
    total++; if (bus.oErr !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", bus.oErr); end
    total++; if (bus.oV !== 4'b0000) begin bad++; $display("FAIL err_v got=%b exp=0000", bus.oV); end
    total++; if (bus.oCount !== 3'd0) begin bad++; $display("FAIL err_count got=%0d exp=0", bus.oCount); end
    write_slot(2'd2, 32'h77); ack = 4'b0100; tick(); idle(); tick();
    total++; if (bus.oErr !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", bus.oErr); end
    do_reset();
    total++; if (bus.oErr !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", bus.oErr); end
  endtask

  task automatic test_random();
    bit held = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!held) begin
        valid = $urandom_range(0, 2) != 0;
        s = 2'($urandom_range(0, 3));
        d = $urandom;
      end
      ack = 4'($urandom) & (($urandom_range(0, 15) == 0) ? 4'b1111 : model_v());
      if ($urandom_range(0, 1) == 0) ack = 4'b0000;
      #1;
      total++; if (bus.oReady !== model_ready()) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, bus.oReady, model_ready()); end
      held = valid && !model_ready() && !rst;
      tick();
      total++; if (bus.oV !== model_v()) begin bad++; $display("FAIL rnd_v cyc=%0d got=%b exp=%b", i, bus.oV, model_v()); end
      total++; if (bus.oCount !== 3'(occupied())) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, bus.oCount, occupied()); end
      total++; if (bus.oCount !== 3'($countones(bus.oV))) begin bad++; $display("FAIL rnd_popcount cyc=%0d got=%0d exp=%0d", i, bus.oCount, $countones(bus.oV)); end
      total++; if (bus.oErr !== merr) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i, bus.oErr, merr); end
      for (int k = 0; k < 4; k++) begin
        total++; if (dut_z(k) !== mz[k]) begin bad++; $display("FAIL rnd_z%0d cyc=%0d got=%h exp=%h", k, i, dut_z(k), mz[k]); end
      end
    end
    idle();
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin mz[k] = '0; mv[k] = 0; end
    merr = 0;
    #2;
    test_reset();
    test_basic();
    test_backpressure();
    test_ack_refill();
    test_fill_multi_ack();
    test_error();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
